// File: rtl/fc_act_pack_ctrl_if.sv
// FC activation pack controller bus.
// Start/config, activation stream and buffer write port.
interface fc_act_pack_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 12
) ();
  logic                       start_i;
  logic [ADDR_WIDTH-1:0]      base_addr_i;
  logic [CNT_WIDTH-1:0]       out_cnt_i;
  logic                       act_last_i;
  logic                       act_valid_i;
  logic [DATA_WIDTH-1:0]      act_result_i;
  logic                       wr_en_o;
  logic [ADDR_WIDTH-1:0]      wr_addr_o;
  logic [DATA_WIDTH*PACK-1:0] wr_data_o;
  logic [PACK-1:0]            wr_strb_o;
  logic                       busy_o;
  logic                       done_o;
  logic                       err_o;

  modport master (
    output start_i, base_addr_i, out_cnt_i,
    output act_last_i, act_valid_i, act_result_i,
    input  wr_en_o, wr_addr_o, wr_data_o, wr_strb_o,
    input  busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, base_addr_i, out_cnt_i,
    input  act_last_i, act_valid_i, act_result_i,
    output wr_en_o, wr_addr_o, wr_data_o, wr_strb_o,
    output busy_o, done_o, err_o
  );
endinterface

// File: rtl/fc_act_pack_ctrl.sv
// FC activation stage sequencer: packs post-ReLU bytes
// into buffer words and reports layer done / mismatch.
module fc_act_pack_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 12
) (
  input logic              clk,
  input logic              rst,
  fc_act_pack_ctrl_if.slave bus
);

  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int WW = DATA_WIDTH * PACK;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  tgt_q, tgt_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [WW-1:0]         pack_q, pack_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WW-1:0]         wr_data_q, wr_data_d;
  logic [PACK-1:0]       wr_strb_q, wr_strb_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [CNT_WIDTH:0]    cnt_nx;
  logic                  hit;
  logic                  fin;
  logic                  full;
  logic [WW-1:0]         merged;
  logic [PACK-1:0]       strb_m;

  always_comb begin
    cnt_nx = {1'b0, cnt_q} + (CNT_WIDTH+1)'(1);
    hit    = (cnt_nx == {1'b0, tgt_q});
    fin    = hit | bus.act_last_i;
    full   = (lane_q == LW'(PACK-1));
    merged = pack_q;
    merged[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH]
           = bus.act_result_i;
    for (int k = 0; k < PACK; k++) begin
      strb_m[k] = (k <= int'(lane_q));
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    lane_d    = lane_q;
    pack_d    = pack_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    wr_strb_d = '0;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          tgt_d  = bus.out_cnt_i;
          addr_d = bus.base_addr_i;
          cnt_d  = '0;
          lane_d = '0;
          pack_d = '0;
          err_d  = 1'b0;
          if (bus.out_cnt_i == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        // stray activations are dropped but flagged
        if (bus.act_valid_i) err_d = 1'b1;
      end
      RUN: begin
        if (bus.act_valid_i) begin
          cnt_d  = cnt_nx[CNT_WIDTH-1:0];
          lane_d = full ? '0 : lane_q + LW'(1);
          pack_d = merged;
          if (full || fin) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = merged;
            wr_strb_d = strb_m;
            addr_d    = addr_q + ADDR_WIDTH'(1);
            pack_d    = '0;
          end
          if (fin) begin
            state_d = DONE;
            done_d  = 1'b1;
            // last and count must coincide
            if (hit != bus.act_last_i) err_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (bus.act_valid_i) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tgt_q     <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;
  assign bus.wr_strb_o = wr_strb_q;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = done_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_fc_act_pack_ctrl.sv
// Bench for fc_act_pack_ctrl: directed table,
// corner sequences and randomized layers vs a model.
module tb_fc_act_pack_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fc_act_pack_ctrl_if #(
    .DATA_WIDTH(8), .PACK(4),
    .ADDR_WIDTH(10), .CNT_WIDTH(12)
  ) bus ();

  fc_act_pack_ctrl #(
    .DATA_WIDTH(8), .PACK(4),
    .ADDR_WIDTH(10), .CNT_WIDTH(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    logic [9:0]  base;
    logic [11:0] cnt;
    logic [7:0]  b0;
    int          last_at;
    int          gap;
    int          nwr;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic [3:0]  s0;
    logic [9:0]  a1;
    logic [31:0] d1;
    logic [3:0]  s1;
    logic        err;
  } vec_t;

  wr_t wq[$];
  wr_t eq[$];
  int  done_cnt;
  int  n_pass;
  int  n_total;

  always @(negedge clk) begin
    if (bus.wr_en_o) begin
      wq.push_back('{bus.wr_addr_o, bus.wr_data_o,
                     bus.wr_strb_o});
    end
    if (bus.done_o) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic idle_in();
    bus.start_i      = 1'b0;
    bus.base_addr_i  = '0;
    bus.out_cnt_i    = '0;
    bus.act_valid_i  = 1'b0;
    bus.act_last_i   = 1'b0;
    bus.act_result_i = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, 64'(bus.wr_en_o), 0);
    chk({tag, "_addr"}, 64'(bus.wr_addr_o), 0);
    chk({tag, "_data"}, 64'(bus.wr_data_o), 0);
    chk({tag, "_strb"}, 64'(bus.wr_strb_o), 0);
    chk({tag, "_busy"}, 64'(bus.busy_o), 0);
    chk({tag, "_done"}, 64'(bus.done_o), 0);
    chk({tag, "_err"}, 64'(bus.err_o), 0);
  endtask

  function automatic int final_idx(input int cnt,
                                   input int last_at);
    if (cnt == 0) return -1;
    if (last_at >= 0 && last_at < cnt) return last_at;
    return cnt - 1;
  endfunction

  // Expected writes: group accepted bytes by word.
  function automatic void model(input logic [9:0] base,
                                input bq_t bytes,
                                input int fin);
    logic [31:0] w;
    logic [3:0]  s;
    eq.delete();
    w = '0;
    s = '0;
    for (int i = 0; i <= fin; i++) begin
      w[(i % 4)*8 +: 8] = bytes[i];
      s[i % 4] = 1'b1;
      if ((i % 4) == 3 || i == fin) begin
        eq.push_back('{base + 10'(i / 4), w, s});
        w = '0;
        s = '0;
      end
    end
  endfunction

  task automatic run_layer(input logic [9:0] base,
                           input logic [11:0] cnt,
                           input bq_t bytes,
                           input int last_at,
                           input int gap,
                           input bit stray,
                           input bit junk);
    int fin;
    fin = final_idx(int'(cnt), last_at);
    wq.delete();
    done_cnt = 0;
    bus.start_i     = 1'b1;
    bus.base_addr_i = base;
    bus.out_cnt_i   = cnt;
    tick();
    idle_in();
    chk("start_busy", 64'(bus.busy_o), 1);
    chk("start_err_clr", 64'(bus.err_o), 0);
    if (fin < 0) begin
      chk("zero_done", 64'(bus.done_o), 1);
      chk("zero_wr", 64'(bus.wr_en_o), 0);
    end
    for (int i = 0; i <= fin; i++) begin
      bus.act_valid_i  = 1'b1;
      bus.act_result_i = bytes[i];
      bus.act_last_i   = (i == last_at);
      if (junk) begin
        bus.start_i     = 1'b1;
        bus.base_addr_i = ~base;
        bus.out_cnt_i   = 12'd1;
      end
      tick();
      idle_in();
      if (i < fin) repeat (gap) tick();
    end
    if (fin >= 0) begin
      chk("fin_done", 64'(bus.done_o), 1);
      chk("fin_wr", 64'(bus.wr_en_o), 1);
      chk("fin_busy", 64'(bus.busy_o), 1);
    end
    bus.act_valid_i = stray;
    if (junk) bus.start_i = 1'b1;
    tick();
    idle_in();
    chk("end_busy", 64'(bus.busy_o), 0);
    chk("end_done", 64'(bus.done_o), 0);
    chk("done_pulses", 64'(done_cnt), 1);
  endtask

  vec_t tv[5];

  initial begin
    bq_t bs;
    logic [9:0]  rb;
    logic [11:0] rc;
    int la, gp, fin, r;
    bit st, jk, e_err;

    n_pass = 0;
    n_total = 0;
    done_cnt = 0;

    tv[0] = '{10'h010, 12'd8, 8'h01, 7, 0, 2,
              10'h010, 32'h04030201, 4'hF,
              10'h011, 32'h08070605, 4'hF, 1'b0};
    tv[1] = '{10'h3FF, 12'd6, 8'h11, 5, 1, 2,
              10'h3FF, 32'h14131211, 4'hF,
              10'h000, 32'h00001615, 4'h3, 1'b0};
    tv[2] = '{10'h020, 12'd8, 8'h21, 2, 0, 1,
              10'h020, 32'h00232221, 4'h7,
              10'h000, 32'h0, 4'h0, 1'b1};
    tv[3] = '{10'h100, 12'd4, 8'h41, 3, 0, 1,
              10'h100, 32'h44434241, 4'hF,
              10'h000, 32'h0, 4'h0, 1'b0};
    tv[4] = '{10'h005, 12'd5, 8'h51, -1, 0, 2,
              10'h005, 32'h54535251, 4'hF,
              10'h006, 32'h00000055, 4'h1, 1'b1};

    idle_in();
    rst = 1'b0;
    repeat (3) tick();
    chk_zero("rst");
    rst = 1'b1;
    tick();
    chk_zero("post_rst");

    for (int v = 0; v < 5; v++) begin
      bs.delete();
      for (int k = 0; k < int'(tv[v].cnt); k++) begin
        bs.push_back(tv[v].b0 + 8'(k));
      end
      run_layer(tv[v].base, tv[v].cnt, bs,
                tv[v].last_at, tv[v].gap, 1'b0, 1'b0);
      chk("tv_nwr", 64'(wq.size()), 64'(tv[v].nwr));
      chk("tv_err", 64'(bus.err_o), 64'(tv[v].err));
      if (wq.size() >= 1) begin
        chk("tv_a0", 64'(wq[0].addr), 64'(tv[v].a0));
        chk("tv_d0", 64'(wq[0].data), 64'(tv[v].d0));
        chk("tv_s0", 64'(wq[0].strb), 64'(tv[v].s0));
      end
      if (tv[v].nwr > 1 && wq.size() >= 2) begin
        chk("tv_a1", 64'(wq[1].addr), 64'(tv[v].a1));
        chk("tv_d1", 64'(wq[1].data), 64'(tv[v].d1));
        chk("tv_s1", 64'(wq[1].strb), 64'(tv[v].s1));
      end
    end

    // stray activation in IDLE
    wq.delete();
    bus.act_valid_i  = 1'b1;
    bus.act_result_i = 8'hAA;
    tick();
    idle_in();
    chk("stray_wr", 64'(bus.wr_en_o), 0);
    chk("stray_err", 64'(bus.err_o), 1);
    chk("stray_busy", 64'(bus.busy_o), 0);
    tick();
    chk("stray_nwr", 64'(wq.size()), 0);

    // reset in the middle of a layer
    wq.delete();
    bus.start_i     = 1'b1;
    bus.base_addr_i = 10'h040;
    bus.out_cnt_i   = 12'd8;
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      bus.act_valid_i  = 1'b1;
      bus.act_result_i = 8'h61 + 8'(k);
      tick();
    end
    idle_in();
    rst = 1'b0;
    tick();
    chk_zero("mid_rst");
    rst = 1'b1;
    tick();
    chk("mid_rst_nwr", 64'(wq.size()), 0);
    bs.delete();
    for (int k = 0; k < 4; k++) bs.push_back(8'h71 + 8'(k));
    run_layer(10'h050, 12'd4, bs, 3, 0, 1'b0, 1'b0);
    chk("after_rst_nwr", 64'(wq.size()), 1);
    if (wq.size() >= 1) begin
      chk("after_rst_a", 64'(wq[0].addr), 64'h050);
      chk("after_rst_d", 64'(wq[0].data), 64'h74737271);
      chk("after_rst_s", 64'(wq[0].strb), 64'hF);
    end

    // zero-length layer with a repeated start in DONE
    bs.delete();
    run_layer(10'h123, 12'd0, bs, -1, 0, 1'b0, 1'b1);
    chk("zero_nwr", 64'(wq.size()), 0);
    chk("zero_err", 64'(bus.err_o), 0);
    tick();
    chk("zero_idle", 64'(bus.busy_o), 0);

    for (int n = 0; n < 40; n++) begin
      rb = 10'($urandom);
      rc = 12'($urandom_range(0, 12));
      bs.delete();
      for (int k = 0; k < int'(rc) + 2; k++) begin
        bs.push_back(8'($urandom));
      end
      r = $urandom_range(0, 3);
      if (rc == 0 || r == 0) la = -1;
      else if (r == 1) la = $urandom_range(0, int'(rc) - 1);
      else la = int'(rc) - 1;
      gp = $urandom_range(0, 2);
      st = ($urandom_range(0, 3) == 0);
      jk = ($urandom_range(0, 3) == 0);
      fin = final_idx(int'(rc), la);
      model(rb, bs, fin);
      if (fin < 0) e_err = st;
      else e_err = st | ((la == fin) != (fin + 1 == int'(rc)));
      run_layer(rb, rc, bs, la, gp, st, jk);
      chk("rnd_nwr", 64'(wq.size()), 64'(eq.size()));
      chk("rnd_err", 64'(bus.err_o), 64'(e_err));
      for (int k = 0; k < eq.size() && k < wq.size(); k++) begin
        chk("rnd_addr", 64'(wq[k].addr), 64'(eq[k].addr));
        chk("rnd_data", 64'(wq[k].data), 64'(eq[k].data));
        chk("rnd_strb", 64'(wq[k].strb), 64'(eq[k].strb));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
